// File: rtl/alu_slice_sequencer_pkg.sv
// Shared widths, 74382 select encodings and sequencer states
// for the bit-serial-by-slice ALU sequencer.
package alu_slice_sequencer_pkg;

  localparam int UINT_16_W      = 16;
  localparam int ORIG_OPERAND_W = 4;
  localparam int SELECT_W       = 3;

  localparam logic [SELECT_W-1:0] SEL_CLEAR     = 3'd0;
  localparam logic [SELECT_W-1:0] SEL_B_MINUS_A = 3'd1;
  localparam logic [SELECT_W-1:0] SEL_A_MINUS_B = 3'd2;
  localparam logic [SELECT_W-1:0] SEL_A_PLUS_B  = 3'd3;
  localparam logic [SELECT_W-1:0] SEL_XOR       = 3'd4;
  localparam logic [SELECT_W-1:0] SEL_OR        = 3'd5;
  localparam logic [SELECT_W-1:0] SEL_AND       = 3'd6;
  localparam logic [SELECT_W-1:0] SEL_PRESET    = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } seq_state_e;

endpackage

// File: rtl/alu_74382.sv
// One 74382-style ALU slice: clear/sub/add/logic/preset,
// active-high carry (carry_in=1 means no borrow).
module alu_74382
  import alu_slice_sequencer_pkg::*;
#(
  parameter int OPERAND_W = ORIG_OPERAND_W,
  parameter int RESULT_W  = ORIG_OPERAND_W
) (
  input  logic [SELECT_W-1:0]  sel,
  input  logic [OPERAND_W-1:0] a,
  input  logic [OPERAND_W-1:0] b,
  input  logic                 carry_in,
  output logic [RESULT_W-1:0]  result,
  output logic                 carry_out,
  output logic                 overflow
);

  logic [OPERAND_W-1:0] x;
  logic [OPERAND_W-1:0] y;
  logic [OPERAND_W-1:0] res;
  logic [OPERAND_W:0]   sum;
  logic                 arith;

  always_comb begin
    x     = '0;
    y     = '0;
    res   = '0;
    arith = 1'b0;
    unique case (sel)
      SEL_CLEAR:     res = '0;
      SEL_B_MINUS_A: begin x = b; y = ~a; arith = 1'b1; end
      SEL_A_MINUS_B: begin x = a; y = ~b; arith = 1'b1; end
      SEL_A_PLUS_B:  begin x = a; y = b;  arith = 1'b1; end
      SEL_XOR:       res = a ^ b;
      SEL_OR:        res = a | b;
      SEL_AND:       res = a & b;
      SEL_PRESET:    res = '1;
      default:       res = '0;
    endcase
    sum = {1'b0, x} + {1'b0, y}
        + {{OPERAND_W{1'b0}}, carry_in};
    carry_out = 1'b0;
    overflow  = 1'b0;
    if (arith) begin
      res       = sum[OPERAND_W-1:0];
      carry_out = sum[OPERAND_W];
      // Signed overflow: like-signed inputs, differently-signed sum
      overflow  = (x[OPERAND_W-1] == y[OPERAND_W-1])
               && (sum[OPERAND_W-1] != x[OPERAND_W-1]);
    end
    result = RESULT_W'(res);
  end

endmodule

// File: rtl/alu_slice_sequencer.sv
// Wide ALU op on one 74382 slice, one slice per clock LSB->MSB,
// inter-slice carry kept in a register.
module alu_slice_sequencer
  import alu_slice_sequencer_pkg::*;
#(
  parameter int OPERAND_W = UINT_16_W,
  parameter int SLICE_W   = ORIG_OPERAND_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [SELECT_W-1:0]  req_sel,
  input  logic                 req_carry_in,
  input  logic [OPERAND_W-1:0] req_port_a,
  input  logic [OPERAND_W-1:0] req_port_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [OPERAND_W-1:0] rsp_result,
  output logic                 rsp_overflow,
  output logic                 rsp_carry_out
);

  localparam int SLICE_QTY = OPERAND_W / SLICE_W;
  localparam int CNT_W =
    (SLICE_QTY > 1) ? $clog2(SLICE_QTY) : 1;

  seq_state_e           state, state_n;
  logic [CNT_W-1:0]     slice_cnt;
  logic                 carry_reg;
  logic [SELECT_W-1:0]  sel_q;
  logic [OPERAND_W-1:0] a_q;
  logic [OPERAND_W-1:0] b_q;
  logic [OPERAND_W-1:0] result_q;
  logic                 ovf_q;
  logic                 cout_q;

  logic [SLICE_W-1:0]   alu_res;
  logic                 alu_cout;
  logic                 alu_ovf;
  logic                 accept;
  logic                 last;

  assign last = (slice_cnt == CNT_W'(SLICE_QTY - 1));

  alu_74382 #(
    .OPERAND_W (SLICE_W),
    .RESULT_W  (SLICE_W)
  ) u_alu (
    .sel       (sel_q),
    .a         (a_q[slice_cnt*SLICE_W +: SLICE_W]),
    .b         (b_q[slice_cnt*SLICE_W +: SLICE_W]),
    .carry_in  (carry_reg),
    .result    (alu_res),
    .carry_out (alu_cout),
    .overflow  (alu_ovf)
  );

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid;
        if (req_valid) state_n = S_EXEC;
      end
      S_EXEC: begin
        if (last) state_n = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      slice_cnt <= '0;
      carry_reg <= 1'b0;
      sel_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      cout_q    <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        sel_q     <= req_sel;
        a_q       <= req_port_a;
        b_q       <= req_port_b;
        carry_reg <= req_carry_in;
        slice_cnt <= '0;
      end
      if (state == S_EXEC) begin
        result_q[slice_cnt*SLICE_W +: SLICE_W] <= alu_res;
        carry_reg <= alu_cout;
        if (last) begin
          ovf_q  <= alu_ovf;
          cout_q <= alu_cout;
        end else begin
          slice_cnt <= slice_cnt + 1'b1;
        end
      end
    end
  end

  assign rsp_result    = result_q;
  assign rsp_overflow  = ovf_q;
  assign rsp_carry_out = cout_q;

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Randomized + directed bench for alu_slice_sequencer against a
// full-width arithmetic reference model.
module tb_alu_slice_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_sel;
  logic        req_carry_in;
  logic [15:0] req_port_a;
  logic [15:0] req_port_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_overflow;
  logic        rsp_carry_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_res;
  logic        exp_co;
  logic        exp_ov;

  always #5 clk = ~clk;

  alu_slice_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_sel       (req_sel),
    .req_carry_in  (req_carry_in),
    .req_port_a    (req_port_a),
    .req_port_b    (req_port_b),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_overflow  (rsp_overflow),
    .rsp_carry_out (rsp_carry_out)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: the slice chain is just a 16-bit adder
  task automatic model(input logic [2:0] s,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic c);
    int x, y, u, sx, sy, sv;
    bit ar;
    ar = 0; x = 0; y = 0;
    exp_res = 16'h0; exp_co = 0; exp_ov = 0;
    case (s)
      3'd0: exp_res = 16'h0000;
      3'd1: begin x = b; y = 16'(~a); ar = 1; end
      3'd2: begin x = a; y = 16'(~b); ar = 1; end
      3'd3: begin x = a; y = b; ar = 1; end
      3'd4: exp_res = a ^ b;
      3'd5: exp_res = a | b;
      3'd6: exp_res = a & b;
      default: exp_res = 16'hFFFF;
    endcase
    if (ar) begin
      u = x + y + int'(c);
      exp_res = u[15:0];
      exp_co = (u > 65535);
      sx = (x > 32767) ? x - 65536 : x;
      sy = (y > 32767) ? y - 65536 : y;
      sv = sx + sy + int'(c);
      exp_ov = (sv > 32767) || (sv < -32768);
    end
  endtask

  task automatic send(input logic [2:0] s, input logic [15:0] a,
                      input logic [15:0] b, input logic c);
    model(s, a, b, c);
    req_sel = s; req_port_a = a; req_port_b = b;
    req_carry_in = c; req_valid = 1'b1;
    chk("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    // Scramble inputs during EXEC; latched copies must win
    req_port_a = 16'($urandom);
    req_port_b = 16'($urandom);
    req_sel = 3'($urandom);
    req_carry_in = 1'($urandom);
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_result"}, rsp_result, exp_res);
    chk({tag, "_carry"}, rsp_carry_out, exp_co);
    chk({tag, "_ovf"}, rsp_overflow, exp_ov);
  endtask

  task automatic take();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("req_ready_back", req_ready, 1);
  endtask

  task automatic run(input string tag, input logic [2:0] s,
                     input logic [15:0] a, input logic [15:0] b,
                     input logic c);
    send(s, a, b, c);
    wait_rsp(tag);
    take();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_sel = '0; req_carry_in = 1'b0;
    req_port_a = '0; req_port_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_flags", {rsp_overflow, rsp_carry_out}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run("add0", 3'd3, 16'h1234, 16'h0FFF, 1'b0);
    chk("add0_lit", rsp_result, 16'h2233);
    run("add_wrap", 3'd3, 16'hFFFF, 16'h0001, 1'b0);
    run("add_ovf", 3'd3, 16'h7FFF, 16'h0001, 1'b0);
    run("sub_brw", 3'd2, 16'h0000, 16'h0001, 1'b1);
    run("sub_ok", 3'd2, 16'h0005, 16'h0003, 1'b1);
    run("and", 3'd6, 16'hF0F0, 16'hFF00, 1'b0);
    run("xor", 3'd4, 16'hAAAA, 16'hFFFF, 1'b0);
    run("bma", 3'd1, 16'h0003, 16'h0010, 1'b1);
    run("clr", 3'd0, 16'h1234, 16'h5678, 1'b1);
    run("pre", 3'd7, 16'h1234, 16'h5678, 1'b0);

    // Backpressure with a pending request waiting for IDLE
    send(3'd3, 16'h4321, 16'h1111, 1'b1);
    wait_rsp("bp");
    req_valid = 1'b1; req_sel = 3'd6;
    req_port_a = 16'hBEEF; req_port_b = 16'h0FF0;
    req_carry_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_ready", req_ready, 0);
      chk("bp_result", rsp_result, exp_res);
      chk("bp_flags", {rsp_overflow, rsp_carry_out},
          {exp_ov, exp_co});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_idle_ready", req_ready, 1);
    chk("bp_idle_valid", rsp_valid, 0);
    model(3'd6, 16'hBEEF, 16'h0FF0, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_accepted", req_ready, 0);
    wait_rsp("bp_next");
    take();

    // Reset in the second EXEC cycle drops the operation
    send(3'd3, 16'h1234, 16'h4321, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_result", rsp_result, 0);
    chk("mid_rst_flags", {rsp_overflow, rsp_carry_out}, 0);
    #2 rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("post_rst_no_rsp", rsp_valid, 0);
    end
    run("post_rst", 3'd3, 16'h1234, 16'h4321, 1'b1);

    // Random ops with random consumer delay
    for (int i = 0; i < 40; i++) begin
      send(3'($urandom), 16'($urandom), 16'($urandom),
           1'($urandom));
      wait_rsp("rnd");
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        chk("rnd_hold", rsp_result, exp_res);
      end
      take();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
